// File: rtl/helix_pkg.sv
// Shared helix4 types and defaults for the action egress path.
package helix_pkg;

  localparam int ACTION_W             = 16;
  localparam int EGRESS_DEPTH         = 8;
  localparam int EGRESS_TOKEN_MAX     = 4;
  localparam int EGRESS_REFILL_PERIOD = 16;

  typedef enum logic [1:0] {
    EG_EMPTY     = 2'd0,
    EG_FLOW      = 2'd1,
    EG_THROTTLED = 2'd2,
    EG_FULL      = 2'd3
  } egress_state_e;

endpackage

// File: rtl/helix_sync_fifo.sv
// Synchronous FIFO with a separately tracked level and a synchronous flush.
module helix_sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [W-1:0]           i_data,
  output logic [W-1:0]           o_data,
  output logic [$clog2(DEPTH):0] o_level,
  output logic [$clog2(DEPTH):0] o_level_next,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [LW-1:0] w_level_next;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);

  // A push in the flush cycle is dropped; a pop only matters when non-empty.
  assign w_push = i_push & ~o_full & ~i_flush;
  assign w_pop  = i_pop & ~o_empty;

  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    w_level_next = r_level;
    if (i_flush)                w_level_next = '0;
    else if (w_push && !w_pop)  w_level_next = r_level + LW'(1);
    else if (w_pop && !w_push)  w_level_next = r_level - LW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep all state updates concurrent.
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_level <= w_level_next;
    end
  end

  // NOTE: storage is not reset; a zero level masks whatever it holds.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data       = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_level      = r_level;
  assign o_level_next = w_level_next;

endmodule

// File: rtl/helix_action_egress.sv
// Aperture action egress: FIFO plus token-bucket release to the world.
// Rate limiting is built only when HELIX_EGRESS_RATE_LIMIT_EN is defined.
module helix_action_egress #(
  parameter int ACTION_W      = helix_pkg::ACTION_W,
  parameter int DEPTH         = helix_pkg::EGRESS_DEPTH,
  parameter int TOKEN_MAX     = helix_pkg::EGRESS_TOKEN_MAX,
  parameter int REFILL_PERIOD = helix_pkg::EGRESS_REFILL_PERIOD
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           act_valid,
  output logic                           act_ready,
  input  logic [ACTION_W-1:0]            act_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ACTION_W-1:0]            out_data,
  input  logic                           flush,
  output logic [$clog2(DEPTH):0]         level,
  output logic [$clog2(TOKEN_MAX):0]     tokens,
  output helix_pkg::egress_state_e       egress_state
);

  import helix_pkg::*;

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TOKEN_MAX) + 1;

  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [LW-1:0] w_level_next;
  logic [TW-1:0] w_tokens;
  logic [TW-1:0] w_tokens_next;
  egress_state_e r_state;
  egress_state_e w_state_next;

  // Ready depends only on registered occupancy, so a full FIFO refuses even when popping.
  assign act_ready = ~w_full;
  assign w_push    = act_valid & act_ready;
  assign w_pop     = out_valid & out_ready;

  helix_sync_fifo #(
    .W     (ACTION_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_push),
    .i_pop        (w_pop),
    .i_flush      (flush),
    .i_data       (act_data),
    .o_data       (out_data),
    .o_level      (level),
    .o_level_next (w_level_next),
    .o_full       (w_full),
    .o_empty      (w_empty)
  );

`ifdef HELIX_EGRESS_RATE_LIMIT_EN
  localparam int CW = $clog2(REFILL_PERIOD);

  logic [CW-1:0] r_refill_cnt;
  logic [TW-1:0] r_tokens;
  logic          w_refill;

  assign w_refill = (r_refill_cnt == CW'(REFILL_PERIOD - 1));

  // A refill and a pop in the same cycle cancel; flush does not touch the bucket.
  always_comb begin
    w_tokens_next = r_tokens;
    if (w_refill && !w_pop) begin
      if (r_tokens != TW'(TOKEN_MAX)) w_tokens_next = r_tokens + TW'(1);
    end else if (w_pop && !w_refill) begin
      w_tokens_next = r_tokens - TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_refill_cnt <= '0;
      r_tokens     <= TW'(TOKEN_MAX);
    end else begin
      r_refill_cnt <= w_refill ? '0 : r_refill_cnt + CW'(1);
      r_tokens     <= w_tokens_next;
    end
  end

  assign w_tokens  = r_tokens;
  assign out_valid = ~w_empty & (r_tokens != '0);
`else
  assign w_tokens      = TW'(TOKEN_MAX);
  assign w_tokens_next = TW'(TOKEN_MAX);
  assign out_valid     = ~w_empty;
`endif

  assign tokens = w_tokens;

  always_comb begin
    w_state_next = EG_FLOW;
    if (w_level_next == LW'(DEPTH))  w_state_next = EG_FULL;
    else if (w_level_next == '0)     w_state_next = EG_EMPTY;
    else if (w_tokens_next == '0)    w_state_next = EG_THROTTLED;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EG_EMPTY;
    else        r_state <= w_state_next;
  end

  assign egress_state = r_state;

endmodule

// File: tb/tb_helix_action_egress.sv
// Self-checking bench for helix_action_egress: directed plan plus random traffic vs a queue model.
module tb_helix_action_egress;

  import helix_pkg::*;

  localparam int DEPTH = EGRESS_DEPTH;
  localparam int TMAX  = EGRESS_TOKEN_MAX;
  localparam int RP    = EGRESS_REFILL_PERIOD;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int TW    = $clog2(TMAX) + 1;
`ifdef HELIX_EGRESS_RATE_LIMIT_EN
  localparam bit RL = 1'b1;
`else
  localparam bit RL = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                act_valid = 1'b0;
  logic                act_ready;
  logic [ACTION_W-1:0] act_data = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [ACTION_W-1:0] out_data;
  logic                flush = 1'b0;
  logic [LW-1:0]       level;
  logic [TW-1:0]       tokens;
  egress_state_e       egress_state;

  always #5 clk = ~clk;

  helix_action_egress dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .act_valid    (act_valid),
    .act_ready    (act_ready),
    .act_data     (act_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .flush        (flush),
    .level        (level),
    .tokens       (tokens),
    .egress_state (egress_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: occupancy, bucket and refill phase as plain integers; payloads in a queue.
  int                  m_level;
  int                  m_tokens;
  int                  m_cnt;
  logic [ACTION_W-1:0] exp_q[$];

  function automatic bit m_valid();
    return (m_level != 0) && (!RL || m_tokens != 0);
  endfunction

  function automatic egress_state_e m_state();
    if (m_level == DEPTH) return EG_FULL;
    if (m_level == 0)     return EG_EMPTY;
    if (m_tokens == 0)    return EG_THROTTLED;
    return EG_FLOW;
  endfunction

  task automatic m_reset();
    m_level  = 0;
    m_tokens = TMAX;
    m_cnt    = 0;
    exp_q.delete();
  endtask

  task automatic m_step();
    bit push, pop, wrap;
    push = act_valid && (m_level != DEPTH);
    pop  = m_valid() && out_ready;
    wrap = (m_cnt == RP - 1);
    if (flush) begin
      m_level = 0;
      exp_q.delete();
    end else begin
      if (push) exp_q.push_back(act_data);
      m_level = m_level + int'(push) - int'(pop);
    end
    if (RL) begin
      if (wrap && !pop)      m_tokens = (m_tokens < TMAX) ? m_tokens + 1 : TMAX;
      else if (pop && !wrap) m_tokens = m_tokens - 1;
    end
    m_cnt = (m_cnt + 1) % RP;
  endtask

  // Monitor: compares on the falling edge, consumes the scoreboard on each handshake.
  initial begin
    m_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) m_reset();
      check("out_valid",    out_valid,    m_valid());
      check("act_ready",    act_ready,    m_level != DEPTH);
      check("level",        level,        m_level);
      check("tokens",       tokens,       m_tokens);
      check("egress_state", egress_state, m_state());
      if (m_level == 0)          check("out_data_empty", out_data, '0);
      else if (exp_q.size() > 0) check("out_data_head",  out_data, exp_q[0]);
      if (out_valid && out_ready) begin
        check("pop_has_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (rst_n) m_step();
    end
  end

  task automatic cyc(input bit v, input bit r, input bit f, input logic [ACTION_W-1:0] d);
    @(posedge clk);
    #1;
    act_valid = v;
    out_ready = r;
    flush     = f;
    act_data  = d;
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cyc(1'b0, r, 1'b0, '0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Burst within budget, then a lone beat while the bucket is empty.
    for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b1, 1'b0, ACTION_W'(16'hA000 + i));
    idle(3, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, ACTION_W'(16'hA005));
    idle(25, 1'b1);

    // Fill to capacity with a ninth beat offered, then drain.
    for (int i = 1; i <= 9; i++) cyc(1'b1, 1'b0, 1'b0, ACTION_W'(16'hD000 + i));
    idle(80, 1'b1);

    // Long idle for saturation.
    idle(100, 1'b0);

    // Flush at level 5 with a push offered, then flush while popping.
    for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, 1'b0, ACTION_W'(16'hF000 + i));
    cyc(1'b1, 1'b0, 1'b1, ACTION_W'(16'hF0FF));
    idle(3, 1'b0);
    for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b0, 1'b0, ACTION_W'(16'hE000 + i));
    cyc(1'b1, 1'b1, 1'b1, ACTION_W'(16'hE0FF));
    idle(5, 1'b1);

    // Random traffic, including the occasional flush.
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 31) == 0, ACTION_W'($urandom));

    // Asynchronous reset in the middle of a burst.
    for (int i = 1; i <= 6; i++) cyc(1'b1, 1'b0, 1'b0, ACTION_W'(16'hB000 + i));
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_level",     level,        '0);
    check("rst_out_valid", out_valid,    1'b0);
    check("rst_act_ready", act_ready,    1'b1);
    check("rst_tokens",    tokens,       TMAX);
    check("rst_state",     egress_state, EG_EMPTY);
    check("rst_out_data",  out_data,     '0);
    act_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 300; i++)
      cyc($urandom_range(0, 1) != 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 63) == 0, ACTION_W'($urandom));
    idle(4, 1'b1);
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
